// File: rtl/comparator_pkg.sv
// Shared encodings and helpers for the serial magnitude comparator.
package comparator_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        CMP_LT = 2'd0,
        CMP_EQ = 2'd1,
        CMP_GT = 2'd2
    } cmp_t;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

endpackage

// File: rtl/comparator_chunk.sv
// Combinational one-hot compare of one DIGIT-wide chunk; flip_msb turns the
// unsigned compare into a two's-complement one for the top chunk.
module comparator_chunk #(
    parameter int DIGIT = 2
) (
    input  logic [DIGIT-1:0] x,
    input  logic [DIGIT-1:0] y,
    input  logic             flip_msb,
    output logic             lt,
    output logic             eq,
    output logic             gt
);

    logic [DIGIT-1:0] mask;
    logic [DIGIT-1:0] xf;
    logic [DIGIT-1:0] yf;

    always_comb begin
        mask            = '0;
        mask[DIGIT-1]   = flip_msb;
        xf              = x ^ mask;
        yf              = y ^ mask;
        lt              = (xf < yf);
        gt              = (xf > yf);
        eq              = (xf == yf);
    end

endmodule

// File: rtl/comparator_serial.sv
// Sequential MSB-first magnitude comparator, DIGIT bits per clock, with
// optional early exit on the first differing chunk.
//
//  state   | meaning
//  IDLE    | waiting for start; results from the last compare are held
//  RUN     | scanning chunks from idx=NCHUNK-1 down to 0
//  DONE    | one-cycle result pulse; a new start is accepted here
module comparator_serial
    import comparator_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int DIGIT      = 2,
    parameter int EARLY_EXIT = 1
) (
    input  logic                                              clk,
    input  logic                                              rst,
    input  logic                                              start,
    input  logic [WIDTH-1:0]                                  a,
    input  logic [WIDTH-1:0]                                  b,
    input  logic                                              is_signed,
    output logic                                              busy,
    output logic                                              done,
    output logic                                              lt,
    output logic                                              eq,
    output logic                                              gt,
    output logic [clog2(WIDTH/((DIGIT > 0) ? DIGIT : 1)+1)-1:0] cycles
);

    localparam int NCHUNK = WIDTH / ((DIGIT > 0) ? DIGIT : 1);
    localparam int CW     = clog2(NCHUNK + 1);
    localparam int IW     = (NCHUNK > 1) ? clog2(NCHUNK) : 1;
    localparam logic [IW-1:0] LAST = IW'(NCHUNK - 1);

    if (DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_param
        $error("comparator_serial: WIDTH must be a non-zero multiple of DIGIT");
    end

    state_t                        state;
    logic [NCHUNK-1:0][DIGIT-1:0]  ra;
    logic [NCHUNK-1:0][DIGIT-1:0]  rb;
    logic                          rsig;
    logic [IW-1:0]                 idx;
    cmp_t                          sticky;
    logic                          c_lt;
    logic                          c_eq;
    logic                          c_gt;
    cmp_t                          chunk_res;
    cmp_t                          first_res;

    comparator_chunk #(.DIGIT(DIGIT)) u_chunk (
        .x        (ra[idx]),
        .y        (rb[idx]),
        .flip_msb (rsig && (idx == LAST)),
        .lt       (c_lt),
        .eq       (c_eq),
        .gt       (c_gt)
    );

    // sticky==CMP_EQ means no difference seen yet, so the MSB-most wins
    always_comb begin
        chunk_res = c_lt ? CMP_LT : (c_gt ? CMP_GT : CMP_EQ);
        first_res = (sticky != CMP_EQ) ? sticky : chunk_res;
    end

    assign busy = (state == ST_RUN);
    assign done = (state == ST_DONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= ST_IDLE;
            ra     <= '0;
            rb     <= '0;
            rsig   <= 1'b0;
            idx    <= '0;
            cycles <= '0;
            sticky <= CMP_EQ;
            lt     <= 1'b0;
            eq     <= 1'b0;
            gt     <= 1'b0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        ra     <= a;
                        rb     <= b;
                        rsig   <= is_signed;
                        idx    <= LAST;
                        cycles <= '0;
                        sticky <= CMP_EQ;
                        lt     <= 1'b0;
                        eq     <= 1'b0;
                        gt     <= 1'b0;
                        state  <= ST_RUN;
                    end else begin
                        state  <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    cycles <= cycles + CW'(1);
                    if ((EARLY_EXIT != 0 && chunk_res != CMP_EQ) || idx == '0) begin
                        lt    <= (first_res == CMP_LT);
                        eq    <= (first_res == CMP_EQ);
                        gt    <= (first_res == CMP_GT);
                        state <= ST_DONE;
                    end else begin
                        if (sticky == CMP_EQ) sticky <= chunk_res;
                        idx <= idx - IW'(1);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
